// File: rtl/spi_regbank_if.sv
// SPI pad-side bundle for spi_regbank.
//   SCLK  : SPI clock from the pad, idles low
//   SV_n  : select, active-low
//   SI    : serial data into the slave
//   SO    : serial data out of the slave
//   so_oe : pad output enable, high while a read data phase is active
// Handshake: a frame is framed by SV_n low; the master changes SI while SCLK is
// low and both sides sample on the SCLK rise (mode 0). The slave moves SO on the
// SCLK fall. There is no valid/ready pair: SV_n low is the only qualifier.
interface spi_regbank_if;
   logic SCLK;
   logic SV_n;
   logic SI;
   logic SO;
   logic so_oe;

   modport master (output SCLK, output SV_n, output SI, input SO, input so_oe);
   modport slave  (input SCLK, input SV_n, input SI, output SO, output so_oe);
endinterface

// File: rtl/spi_regbank.sv
// SPI slave register bank, oversampled in the clk domain.
// Frame: R/W bit (1 = read), ADDR_W address bits, then DATA_W-bit words, MSB
// first, mode 0. Successive words auto-increment the address, wrapping to 0
// after NUM_REGS-1 (or after 2**ADDR_W-1 for an out-of-range start).
// Ports:
//   clk, rst  : system clock (>= 6x SCLK), asynchronous active-high reset
//   spi       : pad bundle (SCLK, SV_n, SI in; SO, so_oe out)
//   regs      : flat register contents, reg k at [k*DATA_W +: DATA_W]
//   wr_stb    : one-clk pulse per committed write
//   wr_addr   : address of the last committed write
//   busy      : synchronised SV_n is low
//   dbg_state : current FSM state (0 IDLE, 1 CMD, 2 DATA)
module spi_regbank #(
   parameter int NUM_REGS    = 8,
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 7,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   spi_regbank_if.slave               spi,
   output logic [NUM_REGS*DATA_W-1:0] regs,
   output logic                       wr_stb,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic                       busy,
   output logic [1:0]                 dbg_state
);

   localparam int CNT_MAX = ((ADDR_W + 1) > DATA_W) ? (ADDR_W + 1) : DATA_W;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Input synchronisers. SV_n resets to 1 so the bank comes out of reset idle.
   logic [SYNC_STAGES-1:0] sclk_sync, svn_sync, si_sync;
   logic                   sclk_d, svn_d;
   logic                   sclk_s, svn_s, si_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync <= '0;
         svn_sync  <= '1;
         si_sync   <= '0;
         sclk_d    <= 1'b0;
         svn_d     <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
         svn_sync  <= {svn_sync[SYNC_STAGES-2:0], spi.SV_n};
         si_sync   <= {si_sync[SYNC_STAGES-2:0], spi.SI};
         sclk_d    <= sclk_s;
         svn_d     <= svn_s;
      end
   end

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign svn_s  = svn_sync[SYNC_STAGES-1];
   assign si_s   = si_sync[SYNC_STAGES-1];

   logic svn_fall, svn_rise, rise_v, fall_v;
   assign svn_fall = svn_d & ~svn_s;
   assign svn_rise = ~svn_d & svn_s;
   // Gating with synchronised SV_n low drops edges while deselected and also
   // lets an abort win over an SCLK edge landing in the same clk.
   assign rise_v   = sclk_s & ~sclk_d & ~svn_s;
   assign fall_v   = ~sclk_s & sclk_d & ~svn_s;

   // Datapath state
   logic [DATA_W-1:0] reg_q [NUM_REGS];
   logic [ADDR_W-1:0] cmd_sh;      // previous ADDR_W command bits
   logic [DATA_W-2:0] dat_sh;      // previous DATA_W-1 write bits
   logic [DATA_W-1:0] out_sh;
   logic [DATA_W-1:0] wr_word;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic              rw_q;
   logic              so_oe_q;
   logic              commit_q;    // completed write word waits one clk
   logic              load_q;      // next fall loads a fresh word
   logic              hold_q;      // first fall after the command keeps the MSB

   logic [ADDR_W:0]   cmd_next;
   logic [DATA_W-1:0] dat_next;
   logic [ADDR_W-1:0] addr_inc;
   logic              addr_hit;
   logic [DATA_W-1:0] rd_cmd, rd_cur;

   assign cmd_next = {cmd_sh, si_s};
   assign dat_next = {dat_sh, si_s};
   assign addr_inc = (addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : addr_q + ADDR_W'(1);

   // Out-of-range addresses read as zero and never match a register.
   always_comb begin
      addr_hit = 1'b0;
      rd_cmd   = '0;
      rd_cur   = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (addr_q == ADDR_W'(k)) begin
            addr_hit = 1'b1;
            rd_cur   = reg_q[k];
         end
         if (cmd_next[ADDR_W-1:0] == ADDR_W'(k)) rd_cmd = reg_q[k];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (svn_fall) state_d = CMD;
         CMD:     if (rise_v && cnt_q == CNT_W'(ADDR_W)) state_d = DATA;
         DATA:    state_d = DATA;
         default: state_d = IDLE;
      endcase
      if (svn_rise) state_d = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_REGS; k++) reg_q[k] <= '0;
         cmd_sh   <= '0;
         dat_sh   <= '0;
         out_sh   <= '0;
         wr_word  <= '0;
         cnt_q    <= '0;
         addr_q   <= '0;
         rw_q     <= 1'b0;
         so_oe_q  <= 1'b0;
         commit_q <= 1'b0;
         load_q   <= 1'b0;
         hold_q   <= 1'b0;
         wr_stb   <= 1'b0;
         wr_addr  <= '0;
      end else begin
         wr_stb <= 1'b0;

         // Commit is independent of the FSM so a word finished just before
         // SV_n rises still lands.
         if (commit_q) begin
            commit_q <= 1'b0;
            addr_q   <= addr_inc;
            if (addr_hit) begin
               wr_stb  <= 1'b1;
               wr_addr <= addr_q;
            end
         end
         for (int k = 0; k < NUM_REGS; k++) begin
            if (commit_q && addr_q == ADDR_W'(k)) reg_q[k] <= wr_word;
         end

         if (svn_rise) begin
            so_oe_q <= 1'b0;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            hold_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: if (svn_fall) cnt_q <= '0;
               CMD: begin
                  if (rise_v) begin
                     cmd_sh <= cmd_next[ADDR_W-1:0];
                     if (cnt_q == CNT_W'(ADDR_W)) begin
                        cnt_q  <= '0;
                        rw_q   <= cmd_next[ADDR_W];
                        addr_q <= cmd_next[ADDR_W-1:0];
                        if (cmd_next[ADDR_W]) begin
                           out_sh  <= rd_cmd;
                           so_oe_q <= 1'b1;
                           hold_q  <= 1'b1;
                        end
                     end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                     end
                  end
               end
               DATA: begin
                  if (rw_q) begin
                     if (rise_v) begin
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                           cnt_q  <= '0;
                           addr_q <= addr_inc;
                           load_q <= 1'b1;
                        end else begin
                           cnt_q <= cnt_q + CNT_W'(1);
                        end
                     end
                     if (fall_v) begin
                        if (hold_q) begin
                           hold_q <= 1'b0;
                        end else if (load_q) begin
                           load_q <= 1'b0;
                           out_sh <= rd_cur;
                        end else begin
                           out_sh <= {out_sh[DATA_W-2:0], 1'b0};
                        end
                     end
                  end else if (rise_v) begin
                     dat_sh <= dat_next[DATA_W-2:0];
                     if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_q    <= '0;
                        wr_word  <= dat_next;
                        commit_q <= 1'b1;
                     end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
      assign regs[g*DATA_W +: DATA_W] = reg_q[g];
   end

   assign spi.SO    = so_oe_q & out_sh[DATA_W-1];
   assign spi.so_oe = so_oe_q;
   assign busy      = ~svn_s;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_regbank.sv
// Directed bench for spi_regbank with default parameters (8 x 8-bit, 7-bit addr).
module tb_spi_regbank;

   localparam int HALF = 5;   // SCLK half period in clk cycles

   logic        clk;
   logic        rst;
   logic [63:0] regs;
   logic        wr_stb;
   logic [6:0]  wr_addr;
   logic        busy;
   logic [1:0]  dbg_state;

   spi_regbank_if bus ();

   spi_regbank #(
      .NUM_REGS(8), .DATA_W(8), .ADDR_W(7), .SYNC_STAGES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .spi(bus.slave),
      .regs(regs),
      .wr_stb(wr_stb),
      .wr_addr(wr_addr),
      .busy(busy),
      .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass;
   int n_total;
   logic [63:0] exp_regs;
   logic [6:0]  stb_q[$];   // observed wr_addr per wr_stb pulse
   logic [6:0]  exp_q[$];   // expected wr_addr per pulse
   logic [63:0] so_bits;
   logic [63:0] oe_bits;

   always @(negedge clk) begin
      if (wr_stb === 1'b1) stb_q.push_back(wr_addr);
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One SPI bit: set SI, sample SO/so_oe just before the rise, then fall.
   task automatic spi_bit(input logic b, output logic so_s, output logic oe_s);
      bus.SI = b;
      wait_clks(HALF);
      so_s = bus.SO;
      oe_s = bus.so_oe;
      bus.SCLK = 1'b1;
      wait_clks(HALF);
      bus.SCLK = 1'b0;
   endtask

   task automatic spi_xfer(input logic [63:0] bits, input int nbits,
                           output logic [63:0] so_o, output logic [63:0] oe_o);
      logic s, o;
      so_o = '0;
      oe_o = '0;
      bus.SV_n = 1'b0;
      wait_clks(HALF);
      for (int i = 0; i < nbits; i++) begin
         spi_bit(bits[nbits-1-i], s, o);
         so_o[nbits-1-i] = s;
         oe_o[nbits-1-i] = o;
      end
      wait_clks(HALF);
      bus.SV_n = 1'b1;
      wait_clks(2 * HALF);
   endtask

   task automatic check_stb(input string name);
      // wr_addr sequence scoreboard
      n_total++;
      if (stb_q.size() != exp_q.size()) begin
         $display("FAIL %s wr_stb count: got %0d expected %0d", name, stb_q.size(), exp_q.size());
      end else begin
         int bad;
         bad = 0;
         foreach (exp_q[i]) if (stb_q[i] !== exp_q[i]) bad++;
         if (bad != 0) $display("FAIL %s wr_addr sequence: %0d entries differ", name, bad);
         else n_pass++;
      end
      stb_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.SCLK = 1'b0;
      bus.SV_n = 1'b1;
      bus.SI   = 1'b0;
      wait_clks(4);
      n_total++;
      if ({regs, wr_stb, wr_addr, busy, bus.SO, bus.so_oe, dbg_state} !== '0)
         $display("FAIL reset outputs: regs=%h stb=%b addr=%h busy=%b so=%b oe=%b st=%0d expected all zero",
                  regs, wr_stb, wr_addr, busy, bus.SO, bus.so_oe, dbg_state);
      else n_pass++;
      rst = 1'b0;
      wait_clks(4);
      n_total++;
      if ({regs, busy, bus.so_oe, dbg_state} !== '0)
         $display("FAIL idle after reset: regs=%h busy=%b oe=%b st=%0d expected zero", regs, busy, bus.so_oe, dbg_state);
      else n_pass++;
      exp_regs = '0;
   endtask

   task automatic test_single_write();
      spi_xfer({1'b0, 7'h03, 8'hA5}, 16, so_bits, oe_bits);
      exp_regs[3*8 +: 8] = 8'hA5;
      exp_q.push_back(7'h03);
      n_total++;
      if (regs !== exp_regs) $display("FAIL single write regs: got %h expected %h", regs, exp_regs);
      else n_pass++;
      check_stb("single write");
   endtask

   task automatic test_single_read();
      spi_xfer({1'b1, 7'h03, 8'h00}, 16, so_bits, oe_bits);
      n_total++;
      if (so_bits[7:0] !== 8'hA5) $display("FAIL single read data: got %h expected a5", so_bits[7:0]);
      else n_pass++;
      n_total++;
      if (oe_bits[15:0] !== 16'h00FF) $display("FAIL single read so_oe: got %h expected 00ff", oe_bits[15:0]);
      else n_pass++;
      n_total++;
      if (bus.so_oe !== 1'b0 || bus.SO !== 1'b0)
         $display("FAIL read end pads: so_oe=%b SO=%b expected 0 0", bus.so_oe, bus.SO);
      else n_pass++;
      check_stb("single read");
   endtask

   task automatic test_burst_write();
      spi_xfer({1'b0, 7'h06, 8'h11, 8'h22, 8'h33}, 32, so_bits, oe_bits);
      exp_regs[6*8 +: 8] = 8'h11;
      exp_regs[7*8 +: 8] = 8'h22;
      exp_regs[0*8 +: 8] = 8'h33;
      exp_q.push_back(7'h06);
      exp_q.push_back(7'h07);
      exp_q.push_back(7'h00);
      n_total++;
      if (regs !== exp_regs) $display("FAIL burst write regs: got %h expected %h", regs, exp_regs);
      else n_pass++;
      check_stb("burst write");
   endtask

   task automatic test_burst_read();
      spi_xfer({1'b1, 7'h07, 16'h0000}, 24, so_bits, oe_bits);
      n_total++;
      if (so_bits[15:0] !== 16'h2233) $display("FAIL burst read data: got %h expected 2233", so_bits[15:0]);
      else n_pass++;
      n_total++;
      if (oe_bits[23:0] !== 24'h00FFFF) $display("FAIL burst read so_oe: got %h expected 00ffff", oe_bits[23:0]);
      else n_pass++;
   endtask

   task automatic test_abort();
      spi_xfer({1'b0, 7'h02, 4'h5}, 12, so_bits, oe_bits);
      n_total++;
      if (regs !== exp_regs) $display("FAIL abort regs: got %h expected %h", regs, exp_regs);
      else n_pass++;
      n_total++;
      if (dbg_state !== 2'd0) $display("FAIL abort state: got %0d expected 0", dbg_state);
      else n_pass++;
      check_stb("abort");
      spi_xfer({1'b0, 7'h02, 8'h5C}, 16, so_bits, oe_bits);
      exp_regs[2*8 +: 8] = 8'h5C;
      exp_q.push_back(7'h02);
      n_total++;
      if (regs !== exp_regs) $display("FAIL after abort regs: got %h expected %h", regs, exp_regs);
      else n_pass++;
      check_stb("after abort");
   endtask

   task automatic test_out_of_range();
      spi_xfer({1'b0, 7'h10, 8'hFF}, 16, so_bits, oe_bits);
      n_total++;
      if (regs !== exp_regs) $display("FAIL oor write regs: got %h expected %h", regs, exp_regs);
      else n_pass++;
      check_stb("oor write");
      spi_xfer({1'b1, 7'h10, 8'h00}, 16, so_bits, oe_bits);
      n_total++;
      if (so_bits[7:0] !== 8'h00 || oe_bits[15:0] !== 16'h00FF)
         $display("FAIL oor read: data %h oe %h expected 00 00ff", so_bits[7:0], oe_bits[15:0]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      logic s, o;
      logic [9:0] bits;
      bits = {1'b1, 7'h03, 2'b00};
      bus.SV_n = 1'b0;
      wait_clks(HALF);
      for (int i = 9; i >= 0; i--) spi_bit(bits[i], s, o);
      wait_clks(2);
      n_total++;
      if (bus.so_oe !== 1'b1 || busy !== 1'b1 || dbg_state !== 2'd2)
         $display("FAIL mid-frame: so_oe=%b busy=%b st=%0d expected 1 1 2", bus.so_oe, busy, dbg_state);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_total++;
      if ({regs, wr_stb, wr_addr, busy, bus.SO, bus.so_oe, dbg_state} !== '0)
         $display("FAIL async reset: regs=%h stb=%b addr=%h busy=%b so=%b oe=%b st=%0d expected all zero",
                  regs, wr_stb, wr_addr, busy, bus.SO, bus.so_oe, dbg_state);
      else n_pass++;
      bus.SV_n = 1'b1;
      bus.SCLK = 1'b0;
      wait_clks(3);
      rst = 1'b0;
      wait_clks(4);
      exp_regs = '0;
      stb_q.delete();
      spi_xfer({1'b0, 7'h01, 8'h3C}, 16, so_bits, oe_bits);
      exp_regs[1*8 +: 8] = 8'h3C;
      exp_q.push_back(7'h01);
      n_total++;
      if (regs !== exp_regs) $display("FAIL post-reset write: got %h expected %h", regs, exp_regs);
      else n_pass++;
      check_stb("post-reset write");
      spi_xfer({1'b1, 7'h01, 8'h00}, 16, so_bits, oe_bits);
      n_total++;
      if (so_bits[7:0] !== 8'h3C) $display("FAIL post-reset read: got %h expected 3c", so_bits[7:0]);
      else n_pass++;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_single_write();
      test_single_read();
      test_burst_write();
      test_burst_read();
      test_abort();
      test_out_of_range();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/spi_regbank.md
Name: spi_regbank

Overview:
- Parametrised SPI slave register bank, oversampled in the system clock domain; the next generation of the 8x8-bit SPI register block.
- Synchronises SCLK/SV_n/SI into `clk` and decodes frames of R/W bit, address and data, MSB first, SPI mode 0.
- Adds generic width/depth, auto-increment burst read/write, a write strobe, out-of-range handling and clean abort on early SV_n deassertion.
- Sits between the chip SPI pads and the core configuration logic.

Parameters:
- NUM_REGS, 8: number of read/write registers, must be 1..2**ADDR_W.
- DATA_W, 8: register and data-word width, must be >= 2.
- ADDR_W, 7: address field width in the frame.
- SYNC_STAGES, 2: synchroniser depth for SCLK, SV_n and SI, must be >= 2.

Ports:
- clk  in  1  system clock; must be >= 6x the SCLK frequency.
- rst  in  1  asynchronous reset, active-high.
- SCLK  in  1  SPI clock from pad; idles low.
- SV_n  in  1  SPI select, active-low.
- SI  in  1  serial data in.
- SO  out  1  serial data out.
- so_oe  out  1  1 while a read data phase is active; used as the pad output enable.
- regs  out  NUM_REGS*DATA_W  flat register contents; reg k occupies bits [k*DATA_W +: DATA_W].
- wr_stb  out  1  one-clk pulse per committed write.
- wr_addr  out  ADDR_W  address of the last committed write.
- busy  out  1  1 whenever SV_n (synchronised) is low.

Behaviour:
- Reset: all of the following go to 0, asynchronously on rst high and held until rst falls:
  - registers, shift registers, bit counter, address counter;
  - SO, so_oe, wr_stb, wr_addr, busy;
  - state returns to IDLE.
- Input sync: SCLK, SV_n and SI each pass through SYNC_STAGES flops.
  - Rising and falling SCLK edges are detected on the synchronised SCLK (one-clk pulses).
  - SI is sampled on the rise pulse.
- Frame format: bit 1 = R/W (1 = read), then ADDR_W address bits, then one or more DATA_W-bit words, all MSB first.
- State IDLE:
  - Synchronised SV_n falling -> CMD; bit counter cleared.
  - SO = 0, so_oe = 0.
- State CMD:
  - Shift SI on each rise pulse.
  - After ADDR_W+1 bits: latch addr and rw, clear the counter, go to DATA.
  - If rw = 1, in the same clk load the out shifter with reg[addr] (0 if addr >= NUM_REGS), drive SO = its MSB and set so_oe = 1.
- State DATA, write:
  - Shift SI on each rise.
  - On the DATA_W-th rise, in the next clk:
    - if addr < NUM_REGS, reg[addr] <= shifted word, wr_stb = 1 for one clk, wr_addr = addr;
    - if addr >= NUM_REGS, no register change and no wr_stb.
  - Then addr advances and the counter clears.
- State DATA, read:
  - On each fall pulse, shift the out shifter left; SO = new MSB.
  - After the DATA_W-th rise, the next fall loads reg[next addr] instead of shifting, so the burst stream is gapless.
- Auto-increment: addr <= addr+1, wrapping to 0 at NUM_REGS.
  - An out-of-range start address increments through to 2**ADDR_W-1, then wraps to 0.
- Read data is captured at word-load time; a write by the same frame to the same address is not visible until the next word load.
- Abort: synchronised SV_n rising in any state -> IDLE in the same clk.
  - Partial command or partial write word discarded, no wr_stb.
  - SO = 0, so_oe = 0, counter cleared.
  - SV_n rising coincident with an SCLK edge pulse: abort wins and the edge is ignored.
  - A completed word whose commit clk coincides with SV_n rising still commits.
- SCLK edges while SV_n is high are ignored.
- busy mirrors synchronised SV_n low.
- Latency:
  - register update at most SYNC_STAGES+2 clk after the final SCLK rise;
  - SO valid at most SYNC_STAGES+2 clk after the SCLK fall.

Test Plan:
- Defaults, write frame 0,0000011,10100101 -> regs[3] = 0xA5; exactly one wr_stb with wr_addr = 3; all other regs 0.
- After that write, read frame 1,0000011 plus 8 clocks -> SO bits 1,0,1,0,0,1,0,1 sampled on SCLK rise; so_oe high only during the 8 data bits.
- Burst write at addr 6 with words 0x11, 0x22, 0x33 -> regs[6] = 0x11, regs[7] = 0x22, regs[0] = 0x33 (wrap); three wr_stb with wr_addr 6, 7, 0.
- Burst read from addr 7 for two words after the previous step -> 0x22 then 0x33, with no gap clock.
- SV_n raised after 12 bits of a write to addr 2 -> regs[2] unchanged, no wr_stb; the next full frame to addr 2 with 0x5C -> regs[2] = 0x5C.
- Write to addr 0x10 -> no change, no wr_stb; read addr 0x10 -> 0x00.
- rst pulsed mid-frame -> all outputs 0 immediately; the next frame decodes correctly.
